// File: rtl/mat_pkg.sv
// Shared definitions for the matrix streaming blocks: the FILL/DRAIN state
// type and the helper that sizes the row/column index counters.
package mat_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Index counters for a dimension of size n hold 0..n-1 and are never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Two-level (outer, inner) index counter. The inner index advances on every
// enable and wraps to zero; the outer index advances on each inner wrap.
// 'last' flags the final position so the owner can change state there.
module mat_idx_counter
    import mat_pkg::*;
#(
    parameter int OUTER_N = 1,
    parameter int INNER_N = 1,
    localparam int OW = cnt_width(OUTER_N),
    localparam int IW = cnt_width(INNER_N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [OW-1:0] outer,
    output logic [IW-1:0] inner,
    output logic          last
);

    localparam logic [OW-1:0] OUTER_MAX = OW'(OUTER_N - 1);
    localparam logic [IW-1:0] INNER_MAX = IW'(INNER_N - 1);

    // Step the inner index, rolling into the outer index; the final position wraps both to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outer <= '0;
            inner <= '0;
        end else if (en) begin
            if (inner == INNER_MAX) begin
                inner <= '0;
                outer <= (outer == OUTER_MAX) ? '0 : outer + 1'b1;
            end else begin
                inner <= inner + 1'b1;
            end
        end
    end

    assign last = (inner == INNER_MAX) && (outer == OUTER_MAX);

endmodule

// File: rtl/mat_stream_transpose.sv
// Streaming matrix transpose. A whole matrix is collected in row-major order
// into a flop buffer (FILL), then replayed in column-major order (DRAIN).
// The two phases never overlap, so one buffer is enough.
module mat_stream_transpose
    import mat_pkg::*;
#(
    parameter int NUM_ROWS   = 1,
    parameter int NUM_COLS   = 1,
    parameter int DATA_WIDTH = 16,
    parameter int FIXED_PNT  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         busy
);

    localparam int RW = cnt_width(NUM_ROWS);
    localparam int CW = cnt_width(NUM_COLS);

    if (NUM_ROWS < 1 || NUM_COLS < 1 || DATA_WIDTH < 1 ||
        FIXED_PNT < 0 || FIXED_PNT >= DATA_WIDTH) begin : g_bad_params
        $error("mat_stream_transpose: invalid parameter combination");
    end

    state_t state;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   busy_q;

    logic [RW-1:0] wr_r;
    logic [CW-1:0] wr_c;
    logic          wr_last;
    logic [RW-1:0] rd_i;
    logic [CW-1:0] rd_j;
    logic          rd_last;
    logic          wr_en;
    logic          rd_en;

    logic signed [DATA_WIDTH-1:0] buffer [NUM_ROWS][NUM_COLS];

    // The ready/valid flags are registered decodes of the state, so a transfer is simply handshake-high
    assign wr_en = in_valid && in_ready_q;
    assign rd_en = out_valid_q && out_ready;

    // Write position: columns step fastest, rows advance on the column wrap
    mat_idx_counter #(
        .OUTER_N (NUM_ROWS),
        .INNER_N (NUM_COLS)
    ) u_wr_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en),
        .outer (wr_r),
        .inner (wr_c),
        .last  (wr_last)
    );

    // Read position: rows step fastest, columns advance on the row wrap
    mat_idx_counter #(
        .OUTER_N (NUM_COLS),
        .INNER_N (NUM_ROWS)
    ) u_rd_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_en),
        .outer (rd_j),
        .inner (rd_i),
        .last  (rd_last)
    );

    // Capture each accepted element; stale contents are harmless because a full FILL precedes every DRAIN
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_r][wr_c] <= in_data;
        end
    end

    // Phase control: a full matrix flips FILL to DRAIN, the last output flips back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (wr_en && wr_last) begin
                        state       <= DRAIN;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (rd_en && rd_last) begin
                        state       <= FILL;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= FILL;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_valid_q ? buffer[rd_i][rd_j] : '0;
    assign out_last  = out_valid_q && rd_last;

endmodule

// File: tb/tb_mat_stream_transpose.sv
// Self-checking bench for mat_stream_transpose. Four instances cover the
// 2x3, 3x2, 1x1 and 2x2 shapes; a fixed table of matrices is followed by
// reset corner cases and randomized matrices checked against a transpose model.
module tb_mat_stream_transpose;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [4];
    logic [15:0] in_data   [4];
    logic        out_ready [4];
    logic        in_ready  [4];
    logic        out_valid [4];
    logic [15:0] out_data  [4];
    logic        out_last  [4];
    logic        busy      [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          k;
        int          n;
        logic [95:0] din;
        logic [95:0] dout;
        int          stall;
        int          gap;
        bit          extra;
    } vec_t;

    vec_t tbl [8];

    mat_stream_transpose #(.NUM_ROWS(2), .NUM_COLS(3), .DATA_WIDTH(16), .FIXED_PNT(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .busy(busy[0]));

    mat_stream_transpose #(.NUM_ROWS(3), .NUM_COLS(2), .DATA_WIDTH(16), .FIXED_PNT(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .busy(busy[1]));

    mat_stream_transpose #(.NUM_ROWS(1), .NUM_COLS(1), .DATA_WIDTH(16), .FIXED_PNT(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_last(out_last[2]), .busy(busy[2]));

    mat_stream_transpose #(.NUM_ROWS(2), .NUM_COLS(2), .DATA_WIDTH(16), .FIXED_PNT(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
        .out_last(out_last[3]), .busy(busy[3]));

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded loops
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int rows_of(input int k);
        case (k)
            0: return 2;
            1: return 3;
            2: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int cols_of(input int k);
        case (k)
            0: return 3;
            1: return 2;
            2: return 1;
            default: return 2;
        endcase
    endfunction

    // Element idx of a table field; element 0 sits in the most significant 16 bits
    function automatic logic [15:0] elem(input logic [95:0] v, input int idx);
        return v[16*(5-idx) +: 16];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0h expected %0h", name, k, act, expv);
        end
    endtask

    // Feed up to stop_in elements, then (if the matrix is complete) drain up to stop_out outputs
    task automatic applyStimulus(input int k, input int n, input logic [15:0] din [6],
                                 input logic [15:0] expv [6], input int stall, input int gap,
                                 input bit extra, input int stop_in, input int stop_out);
        int   i;
        int   cyc;
        int   cnt;
        bit   skip;
        bit   taken;
        bit   rdy;
        bit   held;
        logic [15:0] hd;
        logic hl;

        i   = 0;
        cyc = 0;
        while (i < stop_in && cyc < 200) begin
            checkOutput("fill_out_valid", k, 32'(out_valid[k]), 32'd0);
            checkOutput("fill_out_data", k, 32'(out_data[k]), 32'd0);
            checkOutput("fill_out_last", k, 32'(out_last[k]), 32'd0);
            checkOutput("fill_busy", k, 32'(busy[k]), 32'd0);
            if (gap == 1)      skip = ($urandom_range(0, 2) == 0);
            else if (gap == 2) skip = (cyc % 2 == 1);
            else               skip = 1'b0;
            if (skip) begin
                in_valid[k] = 1'b0;
            end else begin
                in_valid[k] = 1'b1;
                in_data[k]  = din[i];
                checkOutput("fill_in_ready", k, 32'(in_ready[k]), 32'd1);
            end
            taken = !skip && in_ready[k];
            step();
            cyc++;
            if (taken) i++;
        end
        in_valid[k] = 1'b0;
        if (i < stop_in) begin
            checkOutput("fill_timeout", k, 32'(i), 32'(stop_in));
            return;
        end
        if (stop_in < n) return;

        if (extra) begin
            in_valid[k] = 1'b1;
            in_data[k]  = 16'h5A5A;
        end
        cnt  = 0;
        cyc  = 0;
        held = 1'b0;
        hd   = '0;
        hl   = 1'b0;
        while (cnt < n && cyc < 8 * n + 20) begin
            if (stop_out >= 0 && cnt == stop_out) begin
                in_valid[k]  = 1'b0;
                out_ready[k] = 1'b0;
                return;
            end
            if (stall == 0)      rdy = 1'b1;
            else if (stall == 1) rdy = (cyc % 2 == 0);
            else                 rdy = 1'($urandom_range(0, 1));
            out_ready[k] = rdy;
            checkOutput("drain_out_valid", k, 32'(out_valid[k]), 32'd1);
            checkOutput("drain_in_ready", k, 32'(in_ready[k]), 32'd0);
            checkOutput("drain_busy", k, 32'(busy[k]), 32'd1);
            if (held) begin
                checkOutput("stall_data", k, 32'(out_data[k]), 32'(hd));
                checkOutput("stall_last", k, 32'(out_last[k]), 32'(hl));
            end
            if (rdy) begin
                checkOutput("out_data", k, 32'(out_data[k]), 32'(expv[cnt]));
                checkOutput("out_last", k, 32'(out_last[k]), 32'(cnt == n - 1));
                cnt++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                hd   = out_data[k];
                hl   = out_last[k];
            end
            step();
            cyc++;
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        if (cnt < n) checkOutput("drain_timeout", k, 32'(cnt), 32'(n));
        checkOutput("post_in_ready", k, 32'(in_ready[k]), 32'd1);
        checkOutput("post_out_valid", k, 32'(out_valid[k]), 32'd0);
        checkOutput("post_out_data", k, 32'(out_data[k]), 32'd0);
        checkOutput("post_out_last", k, 32'(out_last[k]), 32'd0);
        checkOutput("post_busy", k, 32'(busy[k]), 32'd0);
    endtask

    // Assert reset mid-cycle, confirm the asynchronous effect, then release
    task automatic pulseReset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("rst_in_ready", k, 32'(in_ready[k]), 32'd1);
            checkOutput("rst_out_valid", k, 32'(out_valid[k]), 32'd0);
            checkOutput("rst_out_data", k, 32'(out_data[k]), 32'd0);
            checkOutput("rst_out_last", k, 32'(out_last[k]), 32'd0);
            checkOutput("rst_busy", k, 32'(busy[k]), 32'd0);
        end
        #2 rst_n = 1'b1;
        step();
    endtask

    // Transpose model: output o of an R x C matrix is input element (o mod R, o div R)
    task automatic modelTranspose(input int k, input logic [15:0] din [6], output logic [15:0] expv [6]);
        int r;
        int c;
        for (int o = 0; o < 6; o++) expv[o] = '0;
        for (int o = 0; o < rows_of(k) * cols_of(k); o++) begin
            r = o % rows_of(k);
            c = o / rows_of(k);
            expv[o] = din[r * cols_of(k) + c];
        end
    endtask

    initial begin
        logic [15:0] din  [6];
        logic [15:0] expv [6];
        int          k;
        int          n;

        tbl[0] = '{0, 6, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6},
                         {16'd1, 16'd4, 16'd2, 16'd5, 16'd3, 16'd6}, 0, 0, 1'b0};
        tbl[1] = '{0, 6, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6},
                         {16'd1, 16'd4, 16'd2, 16'd5, 16'd3, 16'd6}, 1, 0, 1'b0};
        tbl[2] = '{1, 6, {16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16},
                         {16'd11, 16'd13, 16'd15, 16'd12, 16'd14, 16'd16}, 0, 2, 1'b1};
        tbl[3] = '{1, 6, {16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26},
                         {16'd21, 16'd23, 16'd25, 16'd22, 16'd24, 16'd26}, 0, 0, 1'b0};
        tbl[4] = '{2, 1, {16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                         {16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 0, 0, 1'b0};
        tbl[5] = '{2, 1, {16'hFFFD, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                         {16'hFFFD, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 0, 0, 1'b0};
        tbl[6] = '{3, 4, {16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0},
                         {16'd1, 16'd3, 16'd2, 16'd4, 16'd0, 16'd0}, 0, 0, 1'b0};
        tbl[7] = '{3, 4, {16'd5, 16'd6, 16'd7, 16'd8, 16'd0, 16'd0},
                         {16'd5, 16'd7, 16'd6, 16'd8, 16'd0, 16'd0}, 0, 0, 1'b0};

        rst_n = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in_valid[j]  = 1'b0;
            in_data[j]   = '0;
            out_ready[j] = 1'b0;
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int j = 0; j < 4; j++) begin
            checkOutput("reset_in_ready", j, 32'(in_ready[j]), 32'd1);
            checkOutput("reset_out_valid", j, 32'(out_valid[j]), 32'd0);
            checkOutput("reset_out_last", j, 32'(out_last[j]), 32'd0);
            checkOutput("reset_out_data", j, 32'(out_data[j]), 32'd0);
            checkOutput("reset_busy", j, 32'(busy[j]), 32'd0);
        end

        $display("[TB] table vectors");
        for (int t = 0; t < 8; t++) begin
            for (int e = 0; e < 6; e++) begin
                din[e]  = elem(tbl[t].din, e);
                expv[e] = elem(tbl[t].dout, e);
            end
            applyStimulus(tbl[t].k, tbl[t].n, din, expv, tbl[t].stall, tbl[t].gap,
                          tbl[t].extra, tbl[t].n, -1);
        end

        $display("[TB] reset mid-fill on 2x2");
        din  = '{16'd99, 16'd98, 16'd97, 16'd0, 16'd0, 16'd0};
        expv = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        applyStimulus(3, 4, din, expv, 0, 0, 1'b0, 3, -1);
        pulseReset();
        din  = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd0, 16'd0};
        expv = '{16'd10, 16'd30, 16'd20, 16'd40, 16'd0, 16'd0};
        applyStimulus(3, 4, din, expv, 0, 0, 1'b0, 4, -1);

        $display("[TB] reset mid-drain on 2x3");
        din  = '{16'd31, 16'd32, 16'd33, 16'd34, 16'd35, 16'd36};
        expv = '{16'd31, 16'd34, 16'd32, 16'd35, 16'd33, 16'd36};
        applyStimulus(0, 6, din, expv, 0, 0, 1'b0, 6, 2);
        pulseReset();
        din  = '{16'd41, 16'd42, 16'd43, 16'd44, 16'd45, 16'd46};
        expv = '{16'd41, 16'd44, 16'd42, 16'd45, 16'd43, 16'd46};
        applyStimulus(0, 6, din, expv, 0, 0, 1'b0, 6, -1);

        $display("[TB] randomized matrices");
        for (int it = 0; it < 40; it++) begin
            k = it % 4;
            n = rows_of(k) * cols_of(k);
            for (int e = 0; e < 6; e++) din[e] = (e < n) ? 16'($urandom) : 16'd0;
            modelTranspose(k, din, expv);
            applyStimulus(k, n, din, expv, 2, int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)), n, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
